// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// mult/multu/div/divu hold busy for a fixed latency; mthi/mtlo write in one cycle.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdOp,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_t;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   state_t          state;
   logic [CW-1:0]   counter;
   logic [WIDTH-1:0] a_q, b_q;
   op_t             op_q;

   logic issue;
   assign issue = (state == IDLE) && start && (mdOp <= 3'd3);

   // NOTE: operand latches carry no reset; they are only read after an issue has loaded them.
   always_ff @(posedge clk) begin
      if (issue) begin
         a_q  <= inA;
         b_q  <= inB;
         op_q <= op_t'(mdOp);
      end
   end

   // Full-width products: operands are extended to 2*WIDTH so the truncated product is exact.
   logic signed [2*WIDTH-1:0] a_sext, b_sext;
   logic        [2*WIDTH-1:0] prod_s, prod_u;
   assign a_sext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign b_sext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign prod_s = $unsigned(a_sext * b_sext);
   assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Dividing by 1 instead of -1 yields the required MIN quotient and zero remainder.
   logic                    b_zero, div_ovf;
   logic signed [WIDTH-1:0] sa, sb_safe;
   logic        [WIDTH-1:0] ub_safe;
   assign b_zero  = (b_q == '0);
   assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
   assign sa      = $signed(a_q);
   assign sb_safe = (b_zero || div_ovf) ? WIDTH'(1) : $signed(b_q);
   assign ub_safe = b_zero ? WIDTH'(1) : b_q;

   logic [WIDTH-1:0] res_hi, res_lo;

   // NOTE: defaults first so every path assigns res_hi/res_lo and no latch is inferred.
   always_comb begin
      res_hi = hi;
      res_lo = lo;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: if (!b_zero) begin
            res_lo = $unsigned(sa / sb_safe);
            res_hi = $unsigned(sa % sb_safe);
         end
         OP_DIVU: if (!b_zero) begin
            res_lo = a_q / ub_safe;
            res_hi = a_q % ub_safe;
         end
         default: ;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         counter <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  counter <= (mdOp <= 3'd1) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
               end else if (start && mdOp == OP_MTHI) begin
                  hi <= inA;
               end else if (start && mdOp == OP_MTLO) begin
                  lo <= inA;
               end
            end
            RUN: begin
               if (counter == CW'(1)) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  counter <= '0;
                  hi      <= res_hi;
                  lo      <= res_lo;
               end else begin
                  counter <= counter - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
